// File: rtl/larpix_rx_pkg.sv
// Shared constants and types for the LArPix_v3 piso lane receiver.
// Packet field positions are provided for capture logic that decodes pkt_data.
package larpix_rx_pkg;

    localparam int WIDTH        = 64;
    localparam int PARITY_BIT   = 63;
    localparam int PKT_TYPE_LSB = 0;
    localparam int PKT_TYPE_MSB = 1;
    localparam int CHIP_ID_LSB  = 2;
    localparam int CHIP_ID_MSB  = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop synchronizer for the serial line plus the per-bit clock counter.
// half_tick marks the start-bit recheck point, bit_tick the mid-bit data/stop sample.
module uart_bit_sampler #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic piso,
    input  logic restart,
    output logic rx_s,
    output logic half_tick,
    output logic bit_tick
);

    localparam logic [7:0] HALF = 8'(CLKS_PER_BIT / 2);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic       sync_p0;
    logic [7:0] cyc_cnt;

    // The counter free-runs modulo CLKS_PER_BIT; restart re-aligns it to a new bit boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b1;
            rx_s    <= 1'b1;
            cyc_cnt <= '0;
        end else begin
            sync_p0 <= piso;
            rx_s    <= sync_p0;
            if (restart || (cyc_cnt == LAST))
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 8'd1;
        end
    end

    assign half_tick = (cyc_cnt == HALF);
    assign bit_tick  = (cyc_cnt == LAST);

endmodule

// File: rtl/piso_packet_rx.sv
// Receiver for one LArPix_v3 piso lane: frames start/64 data/stop bits into packets
// with odd-parity qualification and a valid/ready output register.
module piso_packet_rx #(
    parameter int CLKS_PER_BIT = 2,
    parameter int WIDTH        = larpix_rx_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             piso,
    output logic [WIDTH-1:0] pkt_data,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overflow,
    output logic [15:0]      pkt_count
);

    import larpix_rx_pkg::*;

    localparam int             BCW      = $clog2(WIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    rx_state_t        state;
    logic [BCW-1:0]   bit_cnt;
    logic [WIDTH-1:0] shift;
    logic             rx_s;
    logic             half_tick;
    logic             bit_tick;
    logic             restart;
    logic             complete;

    // Counter alignment: the IDLE detect cycle counts as clock 0 of the start bit,
    // so the recheck and every later sample land mid-bit even at two clocks per bit.
    assign restart = ((state == IDLE) && rx_s)
                   || ((state == START) && half_tick)
                   || (state == BREAK);

    assign complete = (state == STOP) && bit_tick && rx_s;

    uart_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk       (clk),
        .reset_n   (reset_n),
        .piso      (piso),
        .restart   (restart),
        .rx_s      (rx_s),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            pkt_data   <= '0;
            pkt_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            pkt_count  <= '0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;

            // A pending packet is only replaced when it is consumed in the same cycle.
            if (complete) begin
                if (!pkt_valid || pkt_ready) begin
                    pkt_data   <= shift;
                    parity_err <= ~^shift;
                    pkt_valid  <= 1'b1;
                    if (pkt_count != 16'hFFFF)
                        pkt_count <= pkt_count + 16'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s)
                        state <= START;
                end
                START: begin
                    if (half_tick) begin
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift <= {rx_s, shift[WIDTH-1:1]};
                        if (bit_cnt == BIT_LAST)
                            state <= STOP;
                        else
                            bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_packet_rx.sv
// Directed bench for piso_packet_rx: one lane at 2 clocks/bit, one at 4 clocks/bit.
module tb_piso_packet_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        piso = 1'b1;
    logic        piso4 = 1'b1;
    logic        pkt_ready = 1'b0;
    logic [63:0] pkt_data, pkt_data4;
    logic        pkt_valid, pkt_valid4;
    logic        parity_err, parity_err4;
    logic        frame_err, frame_err4;
    logic        overflow, overflow4;
    logic [15:0] pkt_count, pkt_count4;

    int nvec = 0;
    int nerr = 0;
    int fe_cnt = 0, ov_cnt = 0, fe4_cnt = 0, ov4_cnt = 0;
    int fe_snap, ov_snap;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    piso_packet_rx #(.CLKS_PER_BIT(2), .WIDTH(64)) dut (
        .clk(clk), .reset_n(reset_n), .piso(piso), .pkt_data(pkt_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow), .pkt_count(pkt_count)
    );

    piso_packet_rx #(.CLKS_PER_BIT(4), .WIDTH(64)) dut4 (
        .clk(clk), .reset_n(reset_n), .piso(piso4), .pkt_data(pkt_data4),
        .pkt_valid(pkt_valid4), .pkt_ready(1'b1), .parity_err(parity_err4),
        .frame_err(frame_err4), .overflow(overflow4), .pkt_count(pkt_count4)
    );

    // Pulse counters; one increment per clock the pulse is high.
    always @(posedge clk) begin
        fe_cnt  <= fe_cnt  + int'(frame_err);
        ov_cnt  <= ov_cnt  + int'(overflow);
        fe4_cnt <= fe4_cnt + int'(frame_err4);
        ov4_cnt <= ov4_cnt + int'(overflow4);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives start, 64 data bits LSB first, then the given stop bit; entered and left on a negedge.
    task automatic send_frame(input logic [63:0] d, input logic stop_b, input bit on4);
        logic [65:0] f;
        int cpb;
        f = {stop_b, d, 1'b0};
        cpb = on4 ? 4 : 2;
        for (int i = 0; i < 66; i++) begin
            if (on4) piso4 = f[i];
            else     piso  = f[i];
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nvec++; if (pkt_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b exp 0", pkt_valid); end
        nvec++; if (pkt_data !== 64'd0) begin nerr++; $display("FAIL reset_data: got %h exp 0", pkt_data); end
        nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL reset_parity: got %b exp 0", parity_err); end
        nvec++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        nvec++; if (pkt_count !== 16'd0) begin nerr++; $display("FAIL reset_count: got %0d exp 0", pkt_count); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_packet();
        pkt_ready = 1'b1;
        send_frame(64'h8000_0000_0000_0001, 1'b1, 1'b0);
        // Valid must rise exactly 3+HALF+65*CPB cycles after the start bit was driven.
        @(negedge clk);
        nvec++; if (pkt_valid !== 1'b0) begin nerr++; $display("FAIL single_early: got %b exp 0", pkt_valid); end
        @(negedge clk);
        nvec++; if (pkt_valid !== 1'b1) begin nerr++; $display("FAIL single_valid: got %b exp 1", pkt_valid); end
        nvec++; if (pkt_data !== 64'h8000_0000_0000_0001) begin nerr++; $display("FAIL single_data: got %h exp %h", pkt_data, 64'h8000_0000_0000_0001); end
        nvec++; if (parity_err !== 1'b1) begin nerr++; $display("FAIL single_parity1: got %b exp 1", parity_err); end
        nvec++; if (pkt_count !== 16'd1) begin nerr++; $display("FAIL single_count1: got %0d exp 1", pkt_count); end
        @(negedge clk);
        nvec++; if (pkt_valid !== 1'b0) begin nerr++; $display("FAIL single_accept: got %b exp 0", pkt_valid); end
        nvec++; if (pkt_data !== 64'h8000_0000_0000_0001) begin nerr++; $display("FAIL single_hold: got %h exp %h", pkt_data, 64'h8000_0000_0000_0001); end
        send_frame(64'h0000_0000_0000_0001, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        nvec++; if (pkt_data !== 64'h0000_0000_0000_0001) begin nerr++; $display("FAIL single_data2: got %h exp 1", pkt_data); end
        nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL single_parity2: got %b exp 0", parity_err); end
        nvec++; if (pkt_count !== 16'd2) begin nerr++; $display("FAIL single_count2: got %0d exp 2", pkt_count); end
    endtask

    task automatic test_back_to_back();
        exp_cnt = pkt_count + 16'd2;
        send_frame(64'h0000_0000_0000_0007, 1'b1, 1'b0);
        send_frame(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        nvec++; if (pkt_count !== exp_cnt) begin nerr++; $display("FAIL b2b_count: got %0d exp %0d", pkt_count, exp_cnt); end
        nvec++; if (pkt_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin nerr++; $display("FAIL b2b_data: got %h exp %h", pkt_data, 64'hFFFF_FFFF_FFFF_FFFE); end
        nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL b2b_parity: got %b exp 0", parity_err); end
    endtask

    task automatic test_glitch_start();
        piso4 = 1'b0;
        @(negedge clk);
        piso4 = 1'b1;
        repeat (300) @(negedge clk);
        nvec++; if (pkt_count4 !== 16'd0) begin nerr++; $display("FAIL glitch_count: got %0d exp 0", pkt_count4); end
        nvec++; if (pkt_valid4 !== 1'b0) begin nerr++; $display("FAIL glitch_valid: got %b exp 0", pkt_valid4); end
        nvec++; if (fe4_cnt !== 0) begin nerr++; $display("FAIL glitch_frame_err: got %0d exp 0", fe4_cnt); end
        nvec++; if (ov4_cnt !== 0) begin nerr++; $display("FAIL glitch_overflow: got %0d exp 0", ov4_cnt); end
    endtask

    task automatic test_cpb4_frame();
        send_frame(64'h8421_0000_0000_0010, 1'b1, 1'b1);
        nvec++; if (pkt_valid4 !== 1'b0) begin nerr++; $display("FAIL cpb4_early: got %b exp 0", pkt_valid4); end
        @(negedge clk);
        nvec++; if (pkt_valid4 !== 1'b1) begin nerr++; $display("FAIL cpb4_valid: got %b exp 1", pkt_valid4); end
        nvec++; if (pkt_data4 !== 64'h8421_0000_0000_0010) begin nerr++; $display("FAIL cpb4_data: got %h exp %h", pkt_data4, 64'h8421_0000_0000_0010); end
        nvec++; if (parity_err4 !== 1'b0) begin nerr++; $display("FAIL cpb4_parity: got %b exp 0", parity_err4); end
        nvec++; if (pkt_count4 !== 16'd1) begin nerr++; $display("FAIL cpb4_count: got %0d exp 1", pkt_count4); end
    endtask

    task automatic test_bad_stop();
        pkt_ready = 1'b1;
        exp_cnt = pkt_count;
        fe_snap = fe_cnt;
        send_frame(64'h0000_0000_0000_1234, 1'b0, 1'b0);
        piso = 1'b0;
        repeat (20) @(negedge clk);
        nvec++; if (fe_cnt - fe_snap !== 1) begin nerr++; $display("FAIL badstop_pulses: got %0d exp 1", fe_cnt - fe_snap); end
        nvec++; if (pkt_count !== exp_cnt) begin nerr++; $display("FAIL badstop_count: got %0d exp %0d", pkt_count, exp_cnt); end
        nvec++; if (pkt_valid !== 1'b0) begin nerr++; $display("FAIL badstop_valid: got %b exp 0", pkt_valid); end
        piso = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        nvec++; if (pkt_data !== 64'hDEAD_BEEF_0123_4567) begin nerr++; $display("FAIL badstop_good_data: got %h exp %h", pkt_data, 64'hDEAD_BEEF_0123_4567); end
        nvec++; if (parity_err !== 1'b1) begin nerr++; $display("FAIL badstop_good_parity: got %b exp 1", parity_err); end
        nvec++; if (pkt_count !== exp_cnt + 16'd1) begin nerr++; $display("FAIL badstop_good_count: got %0d exp %0d", pkt_count, exp_cnt + 16'd1); end
        nvec++; if (fe_cnt - fe_snap !== 1) begin nerr++; $display("FAIL badstop_total_pulses: got %0d exp 1", fe_cnt - fe_snap); end
    endtask

    task automatic test_backpressure();
        pkt_ready = 1'b0;
        exp_cnt = pkt_count + 16'd1;
        ov_snap = ov_cnt;
        send_frame(64'h0000_0000_0000_00A1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        nvec++; if (pkt_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid_a: got %b exp 1", pkt_valid); end
        send_frame(64'h0000_0000_0000_00B3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        nvec++; if (pkt_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid_held: got %b exp 1", pkt_valid); end
        nvec++; if (pkt_data !== 64'h0000_0000_0000_00A1) begin nerr++; $display("FAIL bp_data_held: got %h exp %h", pkt_data, 64'h00A1); end
        nvec++; if (ov_cnt - ov_snap !== 1) begin nerr++; $display("FAIL bp_overflow: got %0d exp 1", ov_cnt - ov_snap); end
        nvec++; if (pkt_count !== exp_cnt) begin nerr++; $display("FAIL bp_count: got %0d exp %0d", pkt_count, exp_cnt); end
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        nvec++; if (pkt_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain: got %b exp 0", pkt_valid); end
        nvec++; if (pkt_data !== 64'h0000_0000_0000_00A1) begin nerr++; $display("FAIL bp_data_after: got %h exp %h", pkt_data, 64'h00A1); end
    endtask

    task automatic test_simultaneous_accept();
        pkt_ready = 1'b0;
        exp_cnt = pkt_count + 16'd2;
        ov_snap = ov_cnt;
        send_frame(64'h0000_0000_0000_00A1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        nvec++; if (pkt_valid !== 1'b1) begin nerr++; $display("FAIL sim_pending: got %b exp 1", pkt_valid); end
        send_frame(64'h0000_0000_0000_00C3, 1'b1, 1'b0);
        // Ready is high only for the cycle whose closing edge completes packet C.
        @(negedge clk);
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        nvec++; if (pkt_valid !== 1'b1) begin nerr++; $display("FAIL sim_valid: got %b exp 1", pkt_valid); end
        nvec++; if (pkt_data !== 64'h0000_0000_0000_00C3) begin nerr++; $display("FAIL sim_data: got %h exp %h", pkt_data, 64'h00C3); end
        nvec++; if (parity_err !== 1'b1) begin nerr++; $display("FAIL sim_parity: got %b exp 1", parity_err); end
        repeat (2) @(negedge clk);
        nvec++; if (ov_cnt - ov_snap !== 0) begin nerr++; $display("FAIL sim_overflow: got %0d exp 0", ov_cnt - ov_snap); end
        nvec++; if (pkt_count !== exp_cnt) begin nerr++; $display("FAIL sim_count: got %0d exp %0d", pkt_count, exp_cnt); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] d;
        d = 64'h0123_4567_89AB_CDEF;
        pkt_ready = 1'b1;
        piso = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i <= 30; i++) begin
            piso = d[i];
            repeat (2) @(negedge clk);
        end
        reset_n = 1'b0;
        piso = 1'b1;
        #1;
        nvec++; if (pkt_data !== 64'd0) begin nerr++; $display("FAIL midrst_data: got %h exp 0", pkt_data); end
        nvec++; if (pkt_valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %b exp 0", pkt_valid); end
        nvec++; if (parity_err !== 1'b0) begin nerr++; $display("FAIL midrst_parity: got %b exp 0", parity_err); end
        nvec++; if (pkt_count !== 16'd0) begin nerr++; $display("FAIL midrst_count: got %0d exp 0", pkt_count); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        nvec++; if (pkt_valid !== 1'b0) begin nerr++; $display("FAIL midrst_no_partial: got %b exp 0", pkt_valid); end
        send_frame(d, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        nvec++; if (pkt_valid !== 1'b1) begin nerr++; $display("FAIL midrst_valid2: got %b exp 1", pkt_valid); end
        nvec++; if (pkt_data !== d) begin nerr++; $display("FAIL midrst_pkt: got %h exp %h", pkt_data, d); end
        nvec++; if (parity_err !== 1'b1) begin nerr++; $display("FAIL midrst_pkt_parity: got %b exp 1", parity_err); end
        nvec++; if (pkt_count !== 16'd1) begin nerr++; $display("FAIL midrst_pkt_count: got %0d exp 1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_glitch_start();
        test_cpb4_frame();
        test_bad_stop();
        test_backpressure();
        test_simultaneous_accept();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
